ddr_init_sequencer: RTL and testbench

// - Sequences DDR4 power-up/initialisation on the memory clock domain before the controller issues traffic.
// - Drives ddr_reset_n and cke, then issues MRS writes in JEDEC order and an optional ZQCL, each via a valid/ready command port.
// - The command port feeds the command-bus arbiter. Asserts init_done when the memory is ready for traffic.

---
 rtl/ddr_init_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_ddr_init_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_sequencer.sv
// ddr_init_sequencer
// DDR4 power-up / initialisation sequencer on the memory clock domain.
// Walks RESET_n hold, CKE wait, tXPR, the seven MRS writes in JEDEC order
// (MR3,MR6,MR5,MR4,MR2,MR1,MR0), tMOD and an optional ZQCL/tZQinit. Commands
// are offered on a valid/ready port towards the command-bus arbiter.
// Optional feature macro: DDR_INIT_ZQCL_EN (defined -> ZQCL issued after tMOD).
// All outputs are registered; the next-state logic also computes next outputs.
module ddr_init_sequencer #(
    parameter int          T_RESET  = 200,
    parameter int          T_CKE    = 500,
    parameter int          T_XPR    = 30,
    parameter int          T_MRD    = 8,
    parameter int          T_MOD    = 24,
    parameter int          T_ZQINIT = 512,
    parameter int          CNT_W    = 16,
    parameter logic [17:0] MR0_VAL  = 18'h0,
    parameter logic [17:0] MR1_VAL  = 18'h0,
    parameter logic [17:0] MR2_VAL  = 18'h0,
    parameter logic [17:0] MR3_VAL  = 18'h0,
    parameter logic [17:0] MR4_VAL  = 18'h0,
    parameter logic [17:0] MR5_VAL  = 18'h0,
    parameter logic [17:0] MR6_VAL  = 18'h0
) (
    input  logic        clock_t,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [3:0]  cmd_bg_ba,
    output logic [17:0] cmd_addr,
    output logic        ddr_reset_n,
    output logic        cke,
    output logic        init_busy,
    output logic        init_done
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RST_HOLD = 4'd1;
    localparam logic [3:0] S_CKE_WAIT = 4'd2;
    localparam logic [3:0] S_XPR      = 4'd3;
    localparam logic [3:0] S_MRS      = 4'd4;
    localparam logic [3:0] S_MRS_GAP  = 4'd5;
    localparam logic [3:0] S_MOD_WAIT = 4'd6;
    localparam logic [3:0] S_ZQ_ISSUE = 4'd7;
    localparam logic [3:0] S_ZQ_WAIT  = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [2:0] CODE_NOP  = 3'd0;
    localparam logic [2:0] CODE_MRS  = 3'd1;
    localparam logic [2:0] CODE_ZQCL = 3'd2;

    logic [3:0]       state_r;
    logic [3:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_s;
    logic             hs_s;
    logic             cnt_zero_s;
    logic             cmd_valid_s;
    logic [2:0]       cmd_code_s;
    logic [3:0]       cmd_bg_ba_s;
    logic [17:0]      cmd_addr_s;
    logic             ddr_reset_n_s;
    logic             cke_s;
    logic             init_busy_s;
    logic             init_done_s;

    // Sequence position -> mode register number (JEDEC issue order).
    function automatic logic [2:0] mr_of_idx(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd3;
            3'd1:    return 3'd6;
            3'd2:    return 3'd5;
            3'd3:    return 3'd4;
            3'd4:    return 3'd2;
            3'd5:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Mode register number -> address-bus payload.
    function automatic logic [17:0] mr_payload(input logic [2:0] mr);
        case (mr)
            3'd0:    return MR0_VAL;
            3'd1:    return MR1_VAL;
            3'd2:    return MR2_VAL;
            3'd3:    return MR3_VAL;
            3'd4:    return MR4_VAL;
            3'd5:    return MR5_VAL;
            3'd6:    return MR6_VAL;
            default: return 18'h00000;
        endcase
    endfunction

    // Counter load value for a wait of t cycles (entry cycle included).
    function automatic logic [CNT_W-1:0] wait_load(input int t);
        return CNT_W'(t - 1);
    endfunction

    assign hs_s       = cmd_valid & cmd_ready;
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

    // Next state, wait counter and MRS index.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (init_start) begin
                    state_s = S_RST_HOLD;
                    cnt_s   = wait_load(T_RESET);
                end else begin
                    state_s = state_r;
                end
            end
            S_RST_HOLD: begin
                if (cnt_zero_s) begin
                    state_s = S_CKE_WAIT;
                    cnt_s   = wait_load(T_CKE);
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            S_CKE_WAIT: begin
                if (cnt_zero_s) begin
                    state_s = S_XPR;
                    cnt_s   = wait_load(T_XPR);
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            S_XPR: begin
                if (cnt_zero_s) begin
                    state_s = S_MRS;
                    idx_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            S_MRS: begin
                if (hs_s && (idx_r == 3'd6)) begin
                    state_s = S_MOD_WAIT;
                    cnt_s   = wait_load(T_MOD);
                end else if (hs_s) begin
                    state_s = S_MRS_GAP;
                    cnt_s   = wait_load(T_MRD);
                end else begin
                    state_s = S_MRS;
                end
            end
            S_MRS_GAP: begin
                if (cnt_zero_s) begin
                    state_s = S_MRS;
                    idx_s   = idx_r + 3'd1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            S_MOD_WAIT: begin
                if (cnt_zero_s) begin
`ifdef DDR_INIT_ZQCL_EN
                    state_s = S_ZQ_ISSUE;
`else
                    state_s = S_DONE;
`endif
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            S_ZQ_ISSUE: begin
                if (hs_s) begin
                    state_s = S_ZQ_WAIT;
                    cnt_s   = wait_load(T_ZQINIT);
                end else begin
                    state_s = S_ZQ_ISSUE;
                end
            end
            S_ZQ_WAIT: begin
                if (cnt_zero_s) begin
                    state_s = S_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = 3'd0;
            end
        endcase
    end

    // Output values for the state about to be entered.
    always_comb begin
        cmd_valid_s   = 1'b0;
        cmd_code_s    = CODE_NOP;
        cmd_bg_ba_s   = 4'd0;
        cmd_addr_s    = 18'h00000;
        ddr_reset_n_s = (state_s != S_IDLE) && (state_s != S_RST_HOLD);
        cke_s         = (state_s != S_IDLE) && (state_s != S_RST_HOLD) &&
                        (state_s != S_CKE_WAIT);
        init_busy_s   = (state_s != S_IDLE) && (state_s != S_DONE);
        init_done_s   = (state_s == S_DONE);
        case (state_s)
            S_MRS: begin
                cmd_valid_s = 1'b1;
                cmd_code_s  = CODE_MRS;
                cmd_bg_ba_s = {1'b0, mr_of_idx(idx_s)};
                cmd_addr_s  = mr_payload(mr_of_idx(idx_s));
            end
            S_ZQ_ISSUE: begin
                cmd_valid_s = 1'b1;
                cmd_code_s  = CODE_ZQCL;
                cmd_addr_s  = 18'h00400;
            end
            default: begin
                cmd_valid_s = 1'b0;
                cmd_code_s  = CODE_NOP;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts immediately.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= 3'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= CODE_NOP;
            cmd_bg_ba   <= 4'd0;
            cmd_addr    <= 18'h00000;
            ddr_reset_n <= 1'b0;
            cke         <= 1'b0;
            init_busy   <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            cmd_valid   <= cmd_valid_s;
            cmd_code    <= cmd_code_s;
            cmd_bg_ba   <= cmd_bg_ba_s;
            cmd_addr    <= cmd_addr_s;
            ddr_reset_n <= ddr_reset_n_s;
            cke         <= cke_s;
            init_busy   <= init_busy_s;
            init_done   <= init_done_s;
        end
    end

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Testbench for ddr_init_sequencer: a segment-queue model of the init
// timeline is compared against the DUT on every falling edge; directed runs
// pin the model's event cycles to hand-computed values, then randomized
// backpressure / init_start / reset traffic exercises the rest.
module tb_ddr_init_sequencer;

    localparam int T_RESET  = 4;
    localparam int T_CKE    = 5;
    localparam int T_XPR    = 3;
    localparam int T_MRD    = 2;
    localparam int T_MOD    = 3;
    localparam int T_ZQINIT = 6;
    localparam logic [17:0] V0 = 18'h2A000;
    localparam logic [17:0] V1 = 18'h15001;
    localparam logic [17:0] V2 = 18'h0C002;
    localparam logic [17:0] V3 = 18'h00003;
    localparam logic [17:0] V4 = 18'h3F004;
    localparam logic [17:0] V5 = 18'h20005;
    localparam logic [17:0] V6 = 18'h01006;

    logic        clock_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_start = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [3:0]  cmd_bg_ba;
    logic [17:0] cmd_addr;
    logic        ddr_reset_n;
    logic        cke;
    logic        init_busy;
    logic        init_done;

    always #5 clock_t = ~clock_t;

    ddr_init_sequencer #(
        .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD),
        .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT), .CNT_W(16),
        .MR0_VAL(V0), .MR1_VAL(V1), .MR2_VAL(V2), .MR3_VAL(V3),
        .MR4_VAL(V4), .MR5_VAL(V5), .MR6_VAL(V6)
    ) dut (
        .clock_t(clock_t), .reset_n(reset_n), .init_start(init_start),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_bg_ba(cmd_bg_ba), .cmd_addr(cmd_addr), .ddr_reset_n(ddr_reset_n),
        .cke(cke), .init_busy(init_busy), .init_done(init_done)
    );

    // ---------------- behavioural model ----------------
    localparam int K_RST = 0;   // RESET_n low, CKE low
    localparam int K_CKE = 1;   // RESET_n high, CKE low
    localparam int K_WAIT = 2;  // both high, no command
    localparam int K_MRS = 3;   // MRS offered until accepted
    localparam int K_ZQ = 4;    // ZQCL offered until accepted

    typedef struct {
        int         kind;
        int         rem;
        logic [2:0] mr;
    } seg_t;

    typedef struct packed {
        logic        rn;
        logic        cke;
        logic        valid;
        logic [2:0]  code;
        logic [3:0]  bgba;
        logic [17:0] addr;
        logic        busy;
        logic        done;
    } out_t;

    seg_t        q[$];
    bit          m_done = 1'b0;
    logic [17:0] mr_val [0:6];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic seg_t mk(input int kind, input int rem, input logic [2:0] mr);
        seg_t s;
        s.kind = kind;
        s.rem  = rem;
        s.mr   = mr;
        return s;
    endfunction

    task automatic model_load();
        int order [7] = '{3, 6, 5, 4, 2, 1, 0};
        q.delete();
        q.push_back(mk(K_RST, T_RESET, 3'd0));
        q.push_back(mk(K_CKE, T_CKE, 3'd0));
        q.push_back(mk(K_WAIT, T_XPR, 3'd0));
        for (int i = 0; i < 7; i++) begin
            q.push_back(mk(K_MRS, 0, 3'(order[i])));
            q.push_back(mk(K_WAIT, (order[i] == 0) ? T_MOD : T_MRD, 3'd0));
        end
`ifdef DDR_INIT_ZQCL_EN
        q.push_back(mk(K_ZQ, 0, 3'd0));
        q.push_back(mk(K_WAIT, T_ZQINIT, 3'd0));
`endif
    endtask

    task automatic model_clear();
        q.delete();
        m_done = 1'b0;
    endtask

    // Advance the model by one rising edge given the inputs seen at it.
    task automatic model_step(input bit start, input bit ready);
        if (!reset_n) begin
            model_clear();
        end else if (q.size() > 0) begin
            if (q[0].kind == K_MRS || q[0].kind == K_ZQ) begin
                if (ready) void'(q.pop_front());
            end else begin
                q[0].rem = q[0].rem - 1;
                if (q[0].rem == 0) void'(q.pop_front());
            end
            if (q.size() == 0) m_done = 1'b1;
        end else if (start) begin
            m_done = 1'b0;
            model_load();
        end
    endtask

    function automatic out_t model_out();
        out_t o;
        o = '0;
        if (q.size() == 0) begin
            o.rn   = m_done;
            o.cke  = m_done;
            o.done = m_done;
        end else begin
            o.busy = 1'b1;
            case (q[0].kind)
                K_CKE:  o.rn = 1'b1;
                K_WAIT: begin o.rn = 1'b1; o.cke = 1'b1; end
                K_MRS: begin
                    o.rn = 1'b1; o.cke = 1'b1; o.valid = 1'b1;
                    o.code = 3'd1; o.bgba = {1'b0, q[0].mr};
                    o.addr = mr_val[q[0].mr];
                end
                K_ZQ: begin
                    o.rn = 1'b1; o.cke = 1'b1; o.valid = 1'b1;
                    o.code = 3'd2; o.addr = 18'h00400;
                end
                default: o.rn = 1'b0;
            endcase
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clock_t) begin : cmp
        out_t e;
        e = model_out();
        chk("ddr_reset_n", 32'(ddr_reset_n), 32'(e.rn));
        chk("cke", 32'(cke), 32'(e.cke));
        chk("cmd_valid", 32'(cmd_valid), 32'(e.valid));
        chk("cmd_code", 32'(cmd_code), 32'(e.code));
        chk("cmd_bg_ba", 32'(cmd_bg_ba), 32'(e.bgba));
        chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
        chk("init_busy", 32'(init_busy), 32'(e.busy));
        chk("init_done", 32'(init_done), 32'(e.done));
    end

    // ---------------- stimulus helpers ----------------
    int   cyc;
    int   ev[$];
    int   done_cyc;
    int   cke_cyc;
    int   rn_cyc;
    out_t prev;

    task automatic clear_rec();
        ev.delete();
        done_cyc = -1;
        cke_cyc  = -1;
        rn_cyc   = -1;
        cyc      = 0;
        prev     = model_out();
    endtask

    task automatic run_cycle(input bit start, input bit ready);
        out_t o;
        init_start = start;
        cmd_ready  = ready;
        @(posedge clock_t);
        model_step(start, ready);
        #1;
        cyc++;
        o = model_out();
        if (o.valid && !prev.valid) ev.push_back(cyc);
        if (o.done && !prev.done && done_cyc < 0) done_cyc = cyc;
        if (o.cke && cke_cyc < 0) cke_cyc = cyc;
        if (o.rn && rn_cyc < 0) rn_cyc = cyc;
        prev = o;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        init_start = 1'b0;
        cmd_ready  = 1'b0;
        repeat (2) begin
            @(posedge clock_t);
            #1;
        end
        reset_n = 1'b1;
        clear_rec();
    endtask

    task automatic chk_ev(input string name, input int exp[$], input int exp_done);
        chk({name, "_count"}, 32'(ev.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < ev.size(); i++)
            chk({name, "_event"}, 32'(ev[i]), 32'(exp[i]));
        chk({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int e_nom[$];
        int e_bp[$];
        int d_nom;
        int d_bp;
        int late_valid;
        mr_val[0] = V0; mr_val[1] = V1; mr_val[2] = V2; mr_val[3] = V3;
        mr_val[4] = V4; mr_val[5] = V5; mr_val[6] = V6;
`ifdef DDR_INIT_ZQCL_EN
        e_nom = '{13, 16, 19, 22, 25, 28, 31, 35};
        d_nom = 42;
        e_bp  = '{13, 16, 19, 26, 29, 32, 35, 39};
        d_bp  = 46;
`else
        e_nom = '{13, 16, 19, 22, 25, 28, 31};
        d_nom = 35;
        e_bp  = '{13, 16, 19, 26, 29, 32, 35};
        d_bp  = 39;
`endif
        #2;
        chk("reset_valid", 32'(cmd_valid), 32'd0);
        chk("reset_rn", 32'(ddr_reset_n), 32'd0);
        chk("reset_busy", 32'(init_busy), 32'd0);

        // Nominal run, cmd_ready always high.
        do_reset();
        for (int c = 0; c < 50; c++) run_cycle(c == 0, 1'b1);
        chk_ev("nominal", e_nom, d_nom);
        chk("nominal_rn_high", 32'(rn_cyc), 32'd5);
        chk("nominal_cke_high", 32'(cke_cyc), 32'd10);
        chk("nominal_done_pin", 32'(init_done), 32'd1);

        // Backpressure at MR5: cmd_ready low during cycles 19-22.
        do_reset();
        for (int c = 0; c < 55; c++) run_cycle(c == 0, !(c >= 19 && c <= 22));
        chk_ev("backpressure", e_bp, d_bp);

        // Asynchronous reset at cycle 20.
        do_reset();
        for (int c = 0; c < 20; c++) run_cycle(c == 0, 1'b1);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("abort_valid", 32'(cmd_valid), 32'd0);
        chk("abort_rn", 32'(ddr_reset_n), 32'd0);
        chk("abort_cke", 32'(cke), 32'd0);
        chk("abort_busy", 32'(init_busy), 32'd0);
        chk("abort_addr", 32'(cmd_addr), 32'd0);
        repeat (2) run_cycle(1'b0, 1'b1);
        reset_n = 1'b1;
        late_valid = 0;
        for (int c = 0; c < 60; c++) begin
            run_cycle(1'b0, 1'($urandom_range(0, 1)));
            if (cmd_valid) late_valid++;
        end
        chk("abort_no_valid", 32'(late_valid), 32'd0);

        // init_start while busy is ignored; init_start in DONE restarts.
        do_reset();
        for (int c = 0; c < 50; c++) run_cycle(c == 0 || c == 5 || c == 30, 1'b1);
        chk_ev("ignored_start", e_nom, d_nom);
        clear_rec();
        run_cycle(1'b1, 1'b1);
        chk("restart_done", 32'(init_done), 32'd0);
        chk("restart_rn", 32'(ddr_reset_n), 32'd0);
        chk("restart_cke", 32'(cke), 32'd0);
        chk("restart_busy", 32'(init_busy), 32'd1);
        for (int c = 1; c < 50; c++) run_cycle(1'b0, 1'b1);
        chk_ev("restart", e_nom, d_nom);

        // Randomized traffic: random ready, start pulses and resets.
        for (int it = 0; it < 8; it++) begin
            int rst_at;
            do_reset();
            rst_at = (it % 2 == 1) ? int'($urandom_range(20, 250)) : -1;
            for (int c = 0; c < 300; c++) begin
                if (c == rst_at) begin
                    #1;
                    reset_n = 1'b0;
                    model_clear();
                    repeat (2) run_cycle(1'b0, 1'b1);
                    reset_n = 1'b1;
                end
                run_cycle(c == 0 || ($urandom_range(0, 99) < 3),
                          $urandom_range(0, 99) < 60);
            end
        end

        @(posedge clock_t);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
